// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : processor_pkg
// Description : Shared constants, opcode encodings, FSM state type and a
//               sign-extension helper for the 16-bit multi-cycle processor.
// Revision    : 1.0 - initial release
// ============================================================================
package processor_pkg;

  localparam int c_DATA_W   = 16;
  localparam int c_REG_AW   = 4;
  localparam int c_NUM_REGS = 16;

  localparam logic [3:0] c_OP_ADD  = 4'h0;
  localparam logic [3:0] c_OP_SUB  = 4'h1;
  localparam logic [3:0] c_OP_AND  = 4'h2;
  localparam logic [3:0] c_OP_OR   = 4'h3;
  localparam logic [3:0] c_OP_SLL  = 4'h4;
  localparam logic [3:0] c_OP_SRL  = 4'h5;
  localparam logic [3:0] c_OP_ADDI = 4'h6;
  localparam logic [3:0] c_OP_LW   = 4'h7;
  localparam logic [3:0] c_OP_SW   = 4'h8;
  localparam logic [3:0] c_OP_BEQ  = 4'h9;
  localparam logic [3:0] c_OP_BNE  = 4'hA;
  localparam logic [3:0] c_OP_JMP  = 4'hB;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4
  } state_t;

  function automatic logic [c_DATA_W-1:0] sext4(input logic [3:0] v);
    return {{(c_DATA_W-4){v[3]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/processor_regfile.sv
`default_nettype none
// ============================================================================
// Module      : processor_regfile
// Description : 16 x 16-bit register file, two combinational read ports and
//               one synchronous write port. Contents are not reset.
// Ports       : clk                  - rising-edge clock
//               i_we/i_waddr/i_wdata - write port (takes effect at clk edge)
//               i_raddr_a/o_rdata_a  - read port A (combinational)
//               i_raddr_b/o_rdata_b  - read port B (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module processor_regfile
  import processor_pkg::*;
(
  input  logic                clk,
  input  logic                i_we,
  input  logic [c_REG_AW-1:0] i_waddr,
  input  logic [c_DATA_W-1:0] i_wdata,
  input  logic [c_REG_AW-1:0] i_raddr_a,
  output logic [c_DATA_W-1:0] o_rdata_a,
  input  logic [c_REG_AW-1:0] i_raddr_b,
  output logic [c_DATA_W-1:0] o_rdata_b
);

  logic [c_DATA_W-1:0] r_regs [c_NUM_REGS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/multi_cycle_processor.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_processor
// Description : 16-bit multi-cycle CPU core with internal instruction memory,
//               data memory, register file and ALU. Each instruction walks
//               FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// Ports       : clk         - rising-edge clock
//               reset       - synchronous, active-high
//               pc          - program counter
//               instruction - instruction register
//               bus_a       - operand A latch (R[rs])
//               bus_b       - operand B latch (R[rt], or R[rd] for SW/BEQ/BNE)
//               result      - ALU result register
//               data_out    - data memory read register
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_processor
  import processor_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                reset,
  output logic [c_DATA_W-1:0] pc,
  output logic [c_DATA_W-1:0] instruction,
  output logic [c_DATA_W-1:0] bus_a,
  output logic [c_DATA_W-1:0] bus_b,
  output logic [c_DATA_W-1:0] result,
  output logic [c_DATA_W-1:0] data_out
);

  localparam int c_IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int c_DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  state_t r_state;
  state_t w_state_next;

  logic [c_DATA_W-1:0] r_pc;
  logic [c_DATA_W-1:0] r_ir;
  logic [c_DATA_W-1:0] r_bus_a;
  logic [c_DATA_W-1:0] r_bus_b;
  logic [c_DATA_W-1:0] r_result;
  logic [c_DATA_W-1:0] r_data_out;

  // Memories are plain arrays with no reset so they can be preloaded.
  logic [c_DATA_W-1:0] r_imem [IMEM_DEPTH];
  logic [c_DATA_W-1:0] r_dmem [DMEM_DEPTH];

  // Instruction fields
  logic [3:0]          w_op;
  logic [c_REG_AW-1:0] w_rd;
  logic [c_REG_AW-1:0] w_rs;
  logic [c_REG_AW-1:0] w_rt;
  logic [c_DATA_W-1:0] w_imm;

  assign w_op  = r_ir[15:12];
  assign w_rd  = r_ir[11:8];
  assign w_rs  = r_ir[7:4];
  assign w_rt  = r_ir[3:0];
  assign w_imm = sext4(w_rt);

  // SW stores R[rd]; branches compare R[rd] with R[rs], so port B reads rd.
  logic                w_b_uses_rd;
  logic [c_REG_AW-1:0] w_raddr_b;
  logic [c_DATA_W-1:0] w_rdata_a;
  logic [c_DATA_W-1:0] w_rdata_b;
  logic                w_rf_we;
  logic [c_DATA_W-1:0] w_rf_wdata;

  assign w_b_uses_rd = (w_op == c_OP_SW) || (w_op == c_OP_BEQ) || (w_op == c_OP_BNE);
  assign w_raddr_b   = w_b_uses_rd ? w_rd : w_rt;
  // Reset abandons an in-flight WB without touching the register file.
  assign w_rf_we     = (r_state == WB) && !reset;
  assign w_rf_wdata  = (w_op == c_OP_LW) ? r_data_out : r_result;

  processor_regfile u_regfile (
    .clk       (clk),
    .i_we      (w_rf_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (w_raddr_b),
    .o_rdata_b (w_rdata_b)
  );

  // ALU
  logic                w_use_imm;
  logic [c_DATA_W-1:0] w_opb;
  logic [c_DATA_W-1:0] w_alu;
  logic                w_branch_taken;

  assign w_use_imm = (w_op == c_OP_ADDI) || (w_op == c_OP_LW) || (w_op == c_OP_SW);
  assign w_opb     = w_use_imm ? w_imm : r_bus_b;

  always_comb begin
    w_alu = '0;
    case (w_op)
      c_OP_ADD, c_OP_ADDI, c_OP_LW, c_OP_SW: w_alu = r_bus_a + w_opb;
      c_OP_SUB, c_OP_BEQ, c_OP_BNE:          w_alu = r_bus_a - w_opb;
      c_OP_AND:                              w_alu = r_bus_a & r_bus_b;
      c_OP_OR:                               w_alu = r_bus_a | r_bus_b;
      c_OP_SLL:                              w_alu = r_bus_a << r_bus_b[3:0];
      c_OP_SRL:                              w_alu = r_bus_a >> r_bus_b[3:0];
      default:                               w_alu = '0;
    endcase
  end

  assign w_branch_taken = ((w_op == c_OP_BEQ) && (r_bus_b == r_bus_a)) ||
                          ((w_op == c_OP_BNE) && (r_bus_b != r_bus_a));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   w_state_next = DECODE;
      DECODE:  w_state_next = EXECUTE;
      EXECUTE: begin
        if ((w_op == c_OP_LW) || (w_op == c_OP_SW)) begin
          w_state_next = MEM;
        end else if (w_op <= c_OP_ADDI) begin
          w_state_next = WB;
        end else begin
          w_state_next = FETCH;
        end
      end
      MEM:     w_state_next = (w_op == c_OP_LW) ? WB : FETCH;
      WB:      w_state_next = FETCH;
      default: w_state_next = FETCH;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_bus_a    <= '0;
      r_bus_b    <= '0;
      r_result   <= '0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir <= r_imem[r_pc[c_IMEM_AW-1:0]];
          r_pc <= r_pc + 16'd1;
        end
        DECODE: begin
          r_bus_a <= w_rdata_a;
          r_bus_b <= w_rdata_b;
        end
        EXECUTE: begin
          r_result <= w_alu;
          // r_pc already holds the branch address + 1 here.
          if (w_op == c_OP_JMP) begin
            r_pc <= {r_pc[15:12], r_ir[11:0]};
          end else if (w_branch_taken) begin
            r_pc <= r_pc + w_imm;
          end
        end
        MEM: begin
          if (w_op == c_OP_LW) begin
            r_data_out <= r_dmem[r_result[c_DMEM_AW-1:0]];
          end
        end
        default: ;
      endcase
    end
  end

  // Data memory write port
  always_ff @(posedge clk) begin
    if (!reset && (r_state == MEM) && (w_op == c_OP_SW)) begin
      r_dmem[r_result[c_DMEM_AW-1:0]] <= r_bus_b;
    end
  end

  assign pc          = r_pc;
  assign instruction = r_ir;
  assign bus_a       = r_bus_a;
  assign bus_b       = r_bus_b;
  assign result      = r_result;
  assign data_out    = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_processor.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_processor
// Description : Directed self-checking bench for multi_cycle_processor.
//               Expected values are queued with each stimulus step and
//               compared once the DUT has had the cycles to produce them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_processor;

  localparam int K_PC    = 0;
  localparam int K_INSTR = 1;
  localparam int K_BUSA  = 2;
  localparam int K_BUSB  = 3;
  localparam int K_RES   = 4;
  localparam int K_DOUT  = 5;
  localparam int K_REG   = 6;
  localparam int K_DMEM  = 7;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [15:0] exp;
  } sb_item_t;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [15:0] bus_a;
  logic [15:0] bus_b;
  logic [15:0] result;
  logic [15:0] data_out;

  sb_item_t sb[$];
  int n_checks;
  int n_fail;

  multi_cycle_processor #(
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction),
    .bus_a       (bus_a),
    .bus_b       (bus_b),
    .result      (result),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin
      dut.r_imem[i] = 16'h0;
      dut.r_dmem[i] = 16'h0;
    end
    for (int i = 0; i < 16; i++) begin
      dut.u_regfile.r_regs[i] = 16'h0;
    end
  endtask

  task automatic sb_push(input string tag, input int kind, input int idx,
                         input logic [15:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.kind = kind;
    it.idx  = idx;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  function automatic logic [15:0] observe(input int kind, input int idx);
    case (kind)
      K_PC:    return pc;
      K_INSTR: return instruction;
      K_BUSA:  return bus_a;
      K_BUSB:  return bus_b;
      K_RES:   return result;
      K_DOUT:  return data_out;
      K_REG:   return dut.u_regfile.r_regs[idx];
      K_DMEM:  return dut.r_dmem[idx];
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic drain();
    sb_item_t    it;
    logic [15:0] got;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      got = observe(it.kind, it.idx);
      n_checks++;
      assert (got === it.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", it.tag, got, it.exp);
      end
    end
  endtask

  task automatic push_reset_state(input string pfx);
    sb_push({pfx, "_pc"},    K_PC,    0, 16'h0);
    sb_push({pfx, "_instr"}, K_INSTR, 0, 16'h0);
    sb_push({pfx, "_bus_a"}, K_BUSA,  0, 16'h0);
    sb_push({pfx, "_bus_b"}, K_BUSB,  0, 16'h0);
    sb_push({pfx, "_res"},   K_RES,   0, 16'h0);
    sb_push({pfx, "_dout"},  K_DOUT,  0, 16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    tick(2);

    // ---- ADD then BNE taken ----
    clear_all();
    dut.r_imem[0] = 16'h0123;
    dut.r_imem[1] = 16'hA234;
    dut.u_regfile.r_regs[2] = 16'd3;
    dut.u_regfile.r_regs[3] = 16'd4;
    do_reset();
    push_reset_state("reset");
    drain();

    tick(4);
    sb_push("add_r1",    K_REG,   1, 16'h0007);
    sb_push("add_res",   K_RES,   0, 16'h0007);
    sb_push("add_pc",    K_PC,    0, 16'h0001);
    sb_push("add_instr", K_INSTR, 0, 16'h0123);
    drain();

    tick(3);
    sb_push("bne_t_pc",    K_PC,   0, 16'h0006);
    sb_push("bne_t_bus_a", K_BUSA, 0, 16'h0004);
    sb_push("bne_t_bus_b", K_BUSB, 0, 16'h0003);
    sb_push("bne_t_r1",    K_REG,  1, 16'h0007);
    sb_push("bne_t_r2",    K_REG,  2, 16'h0003);
    sb_push("bne_t_r3",    K_REG,  3, 16'h0004);
    drain();

    // ---- ADD then BNE not taken, then a straight-line program ----
    dut.u_regfile.r_regs[2] = 16'd4;
    dut.r_imem[2]    = 16'h1523;  // SUB R5 = R2 - R3
    dut.r_imem[3]    = 16'h8120;  // SW  DM[R2+0] = R1
    dut.r_imem[4]    = 16'h7420;  // LW  R4 = DM[R2+0]
    dut.r_imem[5]    = 16'h5678;  // SRL R6 = R7 >> R8[3:0]
    dut.r_imem[6]    = 16'h6A9F;  // ADDI RA = R9 + (-1)
    dut.r_imem[7]    = 16'hB010;  // JMP 0x010
    dut.r_imem[16]   = 16'h4BC2;  // SLL RB = RC << R2[3:0]
    dut.r_imem[17]   = 16'h9BBE;  // BEQ RB,RB,-2
    do_reset();
    tick(4);
    sb_push("add2_r1", K_REG, 1, 16'h0008);
    drain();
    tick(3);
    sb_push("bne_nt_pc", K_PC,  0, 16'h0002);
    sb_push("bne_nt_r1", K_REG, 1, 16'h0008);
    drain();

    dut.u_regfile.r_regs[2] = 16'd3;
    tick(4);
    sb_push("sub_r5",  K_REG, 5, 16'hFFFF);
    sb_push("sub_res", K_RES, 0, 16'hFFFF);
    sb_push("sub_pc",  K_PC,  0, 16'h0003);
    drain();

    dut.u_regfile.r_regs[1] = 16'h0007;
    sb_push("sw_dm3_before", K_DMEM, 3, 16'h0000);
    drain();
    tick(4);
    sb_push("sw_dm3", K_DMEM, 3, 16'h0007);
    sb_push("sw_pc",  K_PC,   0, 16'h0004);
    drain();

    tick(4);
    sb_push("lw_dout",  K_DOUT, 0, 16'h0007);
    sb_push("lw_r4_c4", K_REG,  4, 16'h0000);
    drain();
    tick(1);
    sb_push("lw_r4", K_REG, 4, 16'h0007);
    sb_push("lw_pc", K_PC,  0, 16'h0005);
    drain();

    dut.u_regfile.r_regs[7] = 16'h8000;
    dut.u_regfile.r_regs[8] = 16'h0013;
    tick(4);
    sb_push("srl_r6", K_REG, 6, 16'h1000);
    sb_push("srl_pc", K_PC,  0, 16'h0006);
    drain();

    tick(4);
    sb_push("addi_ra", K_REG, 10, 16'hFFFF);
    sb_push("addi_pc", K_PC,  0,  16'h0007);
    drain();

    tick(3);
    sb_push("jmp_pc",    K_PC,    0, 16'h0010);
    sb_push("jmp_instr", K_INSTR, 0, 16'hB010);
    drain();

    dut.u_regfile.r_regs[12] = 16'h0001;
    tick(4);
    sb_push("sll_rb", K_REG, 11, 16'h0008);
    sb_push("sll_pc", K_PC,  0,  16'h0011);
    drain();

    tick(3);
    sb_push("beq_t_pc", K_PC, 0, 16'h0010);
    drain();

    // ---- reset during EXECUTE ----
    clear_all();
    dut.r_imem[0] = 16'h0123;
    dut.u_regfile.r_regs[1] = 16'h0055;
    dut.u_regfile.r_regs[2] = 16'd3;
    dut.u_regfile.r_regs[3] = 16'd4;
    do_reset();
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push_reset_state("rst_ex");
    sb_push("rst_ex_r1", K_REG, 1, 16'h0055);
    drain();
    tick(4);
    sb_push("rerun_r1", K_REG, 1, 16'h0007);
    sb_push("rerun_pc", K_PC,  0, 16'h0001);
    drain();

    // ---- reset during WB suppresses the register write ----
    dut.u_regfile.r_regs[1] = 16'h0055;
    do_reset();
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb_push("rst_wb_r1", K_REG, 1, 16'h0055);
    sb_push("rst_wb_pc", K_PC,  0, 16'h0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
